// File: rtl/rv32_ctrl_exec_unit.sv
// Single-cycle RV32I-subset decode/execute slice: control decode, immediates,
// ALU, PC register and next-PC selection. Register file and memories are external.
module rv32_ctrl_exec_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic [31:0] alu_result,
  output logic        alu_zero,
  output logic        reg_write,
  output logic [31:0] reg_wdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_wdata,
  output logic        halt,
  output logic        illegal
);

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] imm, alu_a, alu_b, pc_plus4;
  logic [3:0]      alu_op;
  logic            alu_src, a_is_pc, is_branch, is_jal, is_jalr, is_load, br_taken;
  logic [4:0]      shamt;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  // Base ALU op shared by R-type and I-ALU encodings of funct3
  function automatic logic [3:0] f3_op(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_op = ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  endfunction

  // Control decode; an illegal encoding suppresses every side effect
  always_comb begin
    alu_op    = ALU_ADD;
    alu_src   = 1'b0;
    a_is_pc   = 1'b0;
    imm       = imm_i;
    reg_write = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    halt      = 1'b0;
    illegal   = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_load   = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        alu_op    = f3_op(funct3);
        if (funct7 == 7'b0100000 && funct3 == 3'b000)      alu_op  = ALU_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) alu_op  = ALU_SRA;
        else if (funct7 != 7'b0000000)                     illegal = 1'b1;
      end
      OP_IMM: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = f3_op(funct3);
        if (funct3 == 3'b101 && instruction[30]) alu_op = ALU_SRA;
      end
      OP_LOAD: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
        mem_read  = 1'b1;
        is_load   = 1'b1;
        illegal   = (funct3 != 3'b010);
      end
      OP_STORE: begin
        alu_src   = 1'b1;
        imm       = imm_s;
        mem_write = 1'b1;
        illegal   = (funct3 != 3'b010);
      end
      OP_BRANCH: begin
        is_branch = 1'b1;
        imm       = imm_b;
        case (funct3)
          3'b000, 3'b001: alu_op = ALU_SUB;
          3'b100, 3'b101: alu_op = ALU_SLT;
          3'b110, 3'b111: alu_op = ALU_SLTU;
          default:        illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        reg_write = 1'b1;
        is_jal    = 1'b1;
        imm       = imm_j;
      end
      OP_JALR: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
        is_jalr   = 1'b1;
        illegal   = (funct3 != 3'b000);
      end
      OP_LUI: begin
        alu_src   = 1'b1;
        imm       = imm_u;
        alu_op    = ALU_PASSB;
        reg_write = 1'b1;
      end
      OP_AUIPC: begin
        alu_src   = 1'b1;
        a_is_pc   = 1'b1;
        imm       = imm_u;
        reg_write = 1'b1;
      end
      OP_SYSTEM: halt = 1'b1;
      default:   illegal = 1'b1;
    endcase
    if (illegal) begin
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      halt      = 1'b0;
      is_branch = 1'b0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
      is_load   = 1'b0;
    end
  end

  assign alu_a = a_is_pc ? pc : rs1_data;
  assign alu_b = alu_src ? imm : rs2_data;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:   alu_result = alu_a + alu_b;
      ALU_SUB:   alu_result = alu_a - alu_b;
      ALU_AND:   alu_result = alu_a & alu_b;
      ALU_OR:    alu_result = alu_a | alu_b;
      ALU_XOR:   alu_result = alu_a ^ alu_b;
      ALU_SLL:   alu_result = alu_a << shamt;
      ALU_SRL:   alu_result = alu_a >> shamt;
      ALU_SRA:   alu_result = XLEN'($signed(alu_a) >>> shamt);
      ALU_SLT:   alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:  alu_result = {31'b0, alu_a < alu_b};
      ALU_PASSB: alu_result = alu_b;
      default:   alu_result = '0;
    endcase
  end

  assign alu_zero  = (alu_result == '0);
  assign mem_wdata = rs2_data;
  assign pc_plus4  = pc + XLEN'(4);

  // Branch condition from the ALU zero flag
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000, 3'b101, 3'b111: br_taken = alu_zero;
      3'b001, 3'b100, 3'b110: br_taken = !alu_zero;
      default:                br_taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = pc_plus4;
    if (halt)                        next_pc = pc;
    else if (is_jal)                 next_pc = pc + imm_j;
    else if (is_jalr)                next_pc = alu_result & ~XLEN'(1);
    else if (is_branch && br_taken)  next_pc = pc + imm_b;
  end

  always_comb begin
    reg_wdata = alu_result;
    if (is_jal || is_jalr) reg_wdata = pc_plus4;
    else if (is_load)      reg_wdata = mem_rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= RESET_PC;
    else          pc <= next_pc;
  end

endmodule

// File: tb/tb_rv32_ctrl_exec_unit.sv
// Directed bench for rv32_ctrl_exec_unit: expectations are queued as stimulus is
// applied and drained against the DUT outputs once they settle.
module tb_rv32_ctrl_exec_unit;

  logic        clk, reset_n;
  logic [31:0] instruction, rs1_data, rs2_data, mem_rdata;
  logic [31:0] pc, next_pc, alu_result, reg_wdata, mem_wdata;
  logic        alu_zero, reg_write, mem_write, mem_read, halt, illegal;

  rv32_ctrl_exec_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .mem_rdata(mem_rdata),
    .pc(pc), .next_pc(next_pc), .alu_result(alu_result), .alu_zero(alu_zero),
    .reg_write(reg_write), .reg_wdata(reg_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_wdata(mem_wdata), .halt(halt), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_PC = 0, S_NPC = 1, S_ALU = 2, S_ZERO = 3, S_RW = 4, S_WD = 5,
                 S_MW = 6, S_MR = 7, S_MWD = 8, S_HALT = 9, S_ILL = 10;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int n_pass  = 0;
  int n_total = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] obs(input int s);
    case (s)
      S_PC:    obs = pc;
      S_NPC:   obs = next_pc;
      S_ALU:   obs = alu_result;
      S_ZERO:  obs = {31'b0, alu_zero};
      S_RW:    obs = {31'b0, reg_write};
      S_WD:    obs = reg_wdata;
      S_MW:    obs = {31'b0, mem_write};
      S_MR:    obs = {31'b0, mem_read};
      S_MWD:   obs = mem_wdata;
      S_HALT:  obs = {31'b0, halt};
      default: obs = {31'b0, illegal};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sig, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sig = sig; e.exp = v;
    sb.push_back(e);
  endtask

  // Let combinational outputs settle, then compare every queued expectation
  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_total++;
      assert (obs(e.sig) === e.exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs(e.sig), e.exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] m);
    instruction = ins; rs1_data = a; rs2_data = b; mem_rdata = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    drive(NOP, 0, 0, 0);
    #1 reset_n = 1'b0;
    expect_val("reset_pc", S_PC, 32'h0);
    expect_val("reset_nop_npc", S_NPC, 32'h4);
    drain();
    reset_n = 1'b1;
    tick();
    expect_val("pc_after_release", S_PC, 32'h4);
    drain();
    tick();
    expect_val("pc_8", S_PC, 32'h8);
    drain();
    reset_n = 1'b0;
    expect_val("async_reset_midrun", S_PC, 32'h0);
    drain();
    reset_n = 1'b1;
    tick();
    expect_val("pc_after_rerelease", S_PC, 32'h4);
    drain();

    drive(32'h0020_81B3, 32'd7, 32'hFFFF_FFFF, 0);
    expect_val("add_alu", S_ALU, 32'd6);
    expect_val("add_rw", S_RW, 32'd1);
    expect_val("add_wd", S_WD, 32'd6);
    expect_val("add_zero", S_ZERO, 32'd0);
    expect_val("add_ill", S_ILL, 32'd0);
    drain();

    drive(32'h4020_81B3, 32'd5, 32'd5, 0);
    expect_val("sub_alu", S_ALU, 32'd0);
    expect_val("sub_zero", S_ZERO, 32'd1);
    drain();

    drive(32'h4020_D1B3, 32'h8000_0000, 32'd4, 0);
    expect_val("sra_alu", S_ALU, 32'hF800_0000);
    drain();

    drive(32'h0020_A1B3, 32'hFFFF_FFFF, 32'd1, 0);
    expect_val("slt_alu", S_ALU, 32'd1);
    drain();
    drive(32'h0020_B1B3, 32'hFFFF_FFFF, 32'd1, 0);
    expect_val("sltu_alu", S_ALU, 32'd0);
    drain();

    drive(32'h2020_81B3, 32'd1, 32'd2, 0);
    expect_val("bad_funct7_ill", S_ILL, 32'd1);
    expect_val("bad_funct7_rw", S_RW, 32'd0);
    drain();

    drive(NOP, 0, 0, 0);
    tick(); tick(); tick();
    expect_val("pc_0x10", S_PC, 32'h10);
    drain();

    drive(32'hFE00_0EE3, 32'd9, 32'd9, 0);
    expect_val("beq_taken_npc", S_NPC, 32'h0C);
    expect_val("beq_rw", S_RW, 32'd0);
    drain();
    drive(32'hFE00_0EE3, 32'd9, 32'd8, 0);
    expect_val("beq_not_taken_npc", S_NPC, 32'h14);
    drain();
    tick();
    expect_val("pc_0x14", S_PC, 32'h14);
    drain();

    drive(NOP, 0, 0, 0);
    tick(); tick(); tick();
    expect_val("pc_0x20", S_PC, 32'h20);
    drain();

    drive(32'h0080_00EF, 0, 0, 0);
    expect_val("jal_npc", S_NPC, 32'h28);
    expect_val("jal_wd", S_WD, 32'h24);
    expect_val("jal_rw", S_RW, 32'd1);
    drain();
    tick();
    expect_val("pc_0x28", S_PC, 32'h28);
    drain();

    drive(32'h0040_A103, 32'h100, 32'h0, 32'hDEAD_BEEF);
    expect_val("lw_mr", S_MR, 32'd1);
    expect_val("lw_addr", S_ALU, 32'h104);
    expect_val("lw_wd", S_WD, 32'hDEAD_BEEF);
    expect_val("lw_mw", S_MW, 32'd0);
    drain();

    drive(32'h0020_A423, 32'h100, 32'h5555_AAAA, 0);
    expect_val("sw_addr", S_ALU, 32'h108);
    expect_val("sw_mw", S_MW, 32'd1);
    expect_val("sw_rw", S_RW, 32'd0);
    expect_val("sw_wdata", S_MWD, 32'h5555_AAAA);
    drain();

    drive(32'h1234_50B7, 32'hFFFF_FFFF, 0, 0);
    expect_val("lui_alu", S_ALU, 32'h1234_5000);
    drain();
    drive(32'h0000_1097, 32'hFFFF_FFFF, 0, 0);
    expect_val("auipc_alu", S_ALU, 32'h0000_1028);
    drain();

    drive(32'h0050_8067, 32'h100, 0, 0);
    expect_val("jalr_alu", S_ALU, 32'h105);
    expect_val("jalr_npc", S_NPC, 32'h104);
    expect_val("jalr_wd", S_WD, 32'h2C);
    expect_val("jalr_rd0_rw", S_RW, 32'd1);
    drain();

    drive(32'h0010_0073, 0, 0, 0);
    expect_val("sys_halt", S_HALT, 32'd1);
    expect_val("sys_rw", S_RW, 32'd0);
    expect_val("sys_npc", S_NPC, 32'h28);
    drain();
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_val("sys_pc_hold", S_PC, 32'h28);
      drain();
    end

    drive(32'h0000_007F, 0, 0, 0);
    expect_val("ill_flag", S_ILL, 32'd1);
    expect_val("ill_rw", S_RW, 32'd0);
    expect_val("ill_mw", S_MW, 32'd0);
    expect_val("ill_mr", S_MR, 32'd0);
    expect_val("ill_halt", S_HALT, 32'd0);
    expect_val("ill_npc", S_NPC, 32'h2C);
    drain();
    tick();
    expect_val("ill_pc_adv", S_PC, 32'h2C);
    drain();

    drive(32'h0040_B103, 32'h100, 0, 32'h1);
    expect_val("lw_f3_ill", S_ILL, 32'd1);
    expect_val("lw_f3_mr", S_MR, 32'd0);
    drain();
    drive(32'h0000_2063, 0, 0, 0);
    expect_val("br_f3_010_ill", S_ILL, 32'd1);
    expect_val("br_f3_010_npc", S_NPC, 32'h30);
    drain();

    drive(32'h0000_8067, 32'hFFFF_FFFC, 0, 0);
    expect_val("jalr_to_top_npc", S_NPC, 32'hFFFF_FFFC);
    drain();
    tick();
    drive(NOP, 0, 0, 0);
    expect_val("pc_top", S_PC, 32'hFFFF_FFFC);
    expect_val("pc_wrap_npc", S_NPC, 32'h0);
    drain();
    tick();
    expect_val("pc_wrapped", S_PC, 32'h0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
